// File: rtl/fp_mul_pipe.sv
// Pipelined IEEE-754 multiplier, generic exponent/fraction widths.
// Three stages (unpack/classify, multiply, normalise/round) feed an output
// register; the whole pipe advances in lockstep under a valid/ready handshake.
// Subnormal inputs and tiny results are flushed to zero; rounding is RNE.
module fp_mul_pipe #(
  parameter int EXP_W = 11,
  parameter int MAN_W = 52
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [3:0]             flags
);

  localparam int PW   = 2 * MAN_W + 2;   // full product width
  localparam int XW   = EXP_W + 2;       // signed working exponent width
  localparam int BIAS = 2 ** (EXP_W - 1) - 1;
  localparam int EMAX = 2 ** EXP_W - 1;
  localparam logic [XW-1:0] BIAS_X = XW'(BIAS);
  localparam logic [XW-1:0] EMAX_X = XW'(EMAX);

  typedef enum logic [1:0] {K_NORM, K_QNAN, K_INF, K_ZERO} kind_e;

  typedef struct packed {
    logic             valid;
    logic             sign;
    kind_e            kind;
    logic             invalid;
    logic [EXP_W-1:0] ea;
    logic [EXP_W-1:0] eb;
    logic [MAN_W:0]   ma;
    logic [MAN_W:0]   mb;
  } s1_t;

  typedef struct packed {
    logic          valid;
    logic          sign;
    kind_e         kind;
    logic          invalid;
    logic [XW-1:0] e;
    logic [PW-1:0] p;
  } s2_t;

  typedef struct packed {
    logic             valid;
    logic             sign;
    kind_e            kind;
    logic             invalid;
    logic [XW-1:0]    e;
    logic [MAN_W-1:0] frac;
    logic             inexact;
  } s3_t;

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  s3_t s3_d, s3_q;
  logic                 out_valid_d, out_valid_q;
  logic [EXP_W+MAN_W:0] result_d, result_q;
  logic [3:0]           flags_d, flags_q;

  logic advance;
  assign advance   = en & (~out_valid_q | out_ready);
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan, zero_inf;

  assign {sa, ea, fa} = a;
  assign {sb, eb, fb} = b;

  // Operand classification; exponent 0 covers both zero and flushed subnormals.
  always_comb begin
    a_zero   = (ea == '0);
    b_zero   = (eb == '0);
    a_inf    = (&ea) & (fa == '0);
    b_inf    = (&eb) & (fb == '0);
    a_nan    = (&ea) & (fa != '0);
    b_nan    = (&eb) & (fb != '0);
    a_snan   = a_nan & ~fa[MAN_W-1];
    b_snan   = b_nan & ~fb[MAN_W-1];
    zero_inf = (a_zero & b_inf) | (a_inf & b_zero);
  end

  // Stage 1: capture the accepted pair with its special-case verdict.
  always_comb begin
    // NOTE: each comb output gets a default first (hold) so no latch is inferred.
    s1_d = s1_q;
    if (advance) begin
      s1_d.valid   = in_valid & in_ready;
      s1_d.sign    = sa ^ sb;
      s1_d.ea      = ea;
      s1_d.eb      = eb;
      s1_d.ma      = {1'b1, fa};
      s1_d.mb      = {1'b1, fb};
      s1_d.invalid = a_snan | b_snan | zero_inf;
      if (a_nan | b_nan | zero_inf) s1_d.kind = K_QNAN;
      else if (a_inf | b_inf)       s1_d.kind = K_INF;
      else if (a_zero | b_zero)     s1_d.kind = K_ZERO;
      else                          s1_d.kind = K_NORM;
    end
  end

  // Stage 2: significand product and biased exponent sum.
  always_comb begin
    s2_d = s2_q;
    if (advance) begin
      s2_d.valid   = s1_q.valid;
      s2_d.sign    = s1_q.sign;
      s2_d.kind    = s1_q.kind;
      s2_d.invalid = s1_q.invalid;
      s2_d.e       = {2'b00, s1_q.ea} + {2'b00, s1_q.eb} - BIAS_X;
      s2_d.p       = PW'(s1_q.ma) * PW'(s1_q.mb);
    end
  end

  // Product below its leading one, aligned so the fraction sits at the top.
  logic [PW-2:0]    p_n;
  logic [XW-1:0]    e_n;
  logic [MAN_W-1:0] frac_t;
  logic             g_bit, r_bit, s_bit, rnd_inc;
  logic [MAN_W:0]   frac_r;

  // Normalise by at most one place, then round to nearest even.
  always_comb begin
    p_n     = s2_q.p[PW-1] ? s2_q.p[PW-2:0] : {s2_q.p[PW-3:0], 1'b0};
    e_n     = s2_q.e + XW'(s2_q.p[PW-1]);
    frac_t  = p_n[PW-2 -: MAN_W];
    g_bit   = p_n[MAN_W];
    r_bit   = p_n[MAN_W-1];
    s_bit   = |p_n[MAN_W-2:0];
    rnd_inc = g_bit & (r_bit | s_bit | frac_t[0]);
    // A carry out leaves the low bits all zero, i.e. a significand of 1.0.
    frac_r  = {1'b0, frac_t} + (MAN_W+1)'(rnd_inc);
  end

  // Stage 3: register the rounded fraction and final exponent.
  always_comb begin
    s3_d = s3_q;
    if (advance) begin
      s3_d.valid   = s2_q.valid;
      s3_d.sign    = s2_q.sign;
      s3_d.kind    = s2_q.kind;
      s3_d.invalid = s2_q.invalid;
      s3_d.e       = e_n + XW'(frac_r[MAN_W]);
      s3_d.frac    = frac_r[MAN_W-1:0];
      s3_d.inexact = g_bit | r_bit | s_bit;
    end
  end

  // Output register: range check, pack and flag assembly.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    if (advance) begin
      out_valid_d = s3_q.valid;
      if (s3_q.kind == K_QNAN) begin
        result_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        flags_d  = {s3_q.invalid, 3'b000};
      end else if (s3_q.kind == K_INF) begin
        result_d = {s3_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        flags_d  = 4'b0000;
      end else if (s3_q.kind == K_ZERO) begin
        result_d = {s3_q.sign, {(EXP_W+MAN_W){1'b0}}};
        flags_d  = 4'b0000;
      end else if ($signed(s3_q.e) >= $signed(EMAX_X)) begin
        result_d = {s3_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        flags_d  = 4'b0101;
      end else if (s3_q.e[XW-1] || (s3_q.e == '0)) begin
        result_d = {s3_q.sign, {(EXP_W+MAN_W){1'b0}}};
        flags_d  = 4'b0011;
      end else begin
        result_d = {s3_q.sign, s3_q.e[EXP_W-1:0], s3_q.frac};
        flags_d  = {3'b000, s3_q.inexact};
      end
    end
  end

  // All pipeline state; synchronous reset clears every stage.
  always_ff @(posedge clk) begin
    // NOTE: datapath fields are reset as well because result/flags must read 0 out of reset.
    if (rst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      s3_q        <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every stage samples pre-edge values.
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

endmodule
